// File: rtl/scan_sequencer_p.sv
// Raster scan sequencer: walks an (x,y) grid from ORIGIN to the latched limits.
// Each point gets STAGES PROCESS cycles and one ANALYZE handshake beat.
module scan_sequencer_p #(
  parameter int CW     = 4,
  parameter int STAGES = 4,
  parameter int ORIGIN = 1,
  parameter int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CW-1:0]   cfg_xmax,
  input  logic [CW-1:0]   cfg_ymax,
  input  logic            cfg_order,
  input  logic            ana_ready,
  input  logic            abort,
  output logic            busy,
  output logic [CW-1:0]   x,
  output logic [CW-1:0]   y,
  output logic [SW-1:0]   stage,
  output logic            analyze_en,
  output logic            valid,
  output logic            cfg_err,
  output logic [2*CW-1:0] pt_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECV    = 3'd1;
  localparam logic [2:0] S_PROCESS = 3'd2;
  localparam logic [2:0] S_ANALYZE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CW-1:0] ORG      = CW'(ORIGIN);
  localparam logic [SW-1:0] STG_LAST = SW'(STAGES - 1);

  logic [2:0]      r_state;
  logic [CW-1:0]   r_x, r_y, r_xmax, r_ymax;
  logic            r_order;
  logic [SW-1:0]   r_stage;
  logic [2*CW-1:0] r_pt_cnt;
  logic            r_cfg_err;

  logic w_cfg_ok, w_x_end, w_y_end;

  assign w_cfg_ok = (cfg_xmax >= ORG) && (cfg_ymax >= ORG);
  assign w_x_end  = (r_x == r_xmax);
  assign w_y_end  = (r_y == r_ymax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= ORG;
      r_y       <= ORG;
      r_xmax    <= ORG;
      r_ymax    <= ORG;
      r_order   <= 1'b0;
      r_stage   <= '0;
      r_pt_cnt  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      // abort wins over every other transition but leaves pt_cnt for inspection
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_x     <= ORG;
        r_y     <= ORG;
        r_stage <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (en) begin
              if (w_cfg_ok) begin
                r_xmax   <= cfg_xmax;
                r_ymax   <= cfg_ymax;
                r_order  <= cfg_order;
                r_pt_cnt <= '0;
                r_state  <= S_RECV;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          S_RECV: begin
            r_stage <= '0;
            r_state <= S_PROCESS;
          end
          S_PROCESS: begin
            if (r_stage == STG_LAST) begin
              r_stage <= '0;
              r_state <= S_ANALYZE;
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end
          S_ANALYZE: begin
            if (ana_ready) begin
              if (!(&r_pt_cnt)) r_pt_cnt <= r_pt_cnt + 1'b1;
              // last-point test comes first, so max-range limits never wrap
              if (w_x_end && w_y_end) begin
                r_x     <= ORG;
                r_y     <= ORG;
                r_state <= S_DONE;
              end else begin
                r_state <= S_PROCESS;
                if (!r_order) begin
                  if (w_y_end) begin
                    r_x <= r_x + 1'b1;
                    r_y <= ORG;
                  end else begin
                    r_y <= r_y + 1'b1;
                  end
                end else begin
                  if (w_x_end) begin
                    r_y <= r_y + 1'b1;
                    r_x <= ORG;
                  end else begin
                    r_x <= r_x + 1'b1;
                  end
                end
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign analyze_en = (r_state == S_ANALYZE);
  assign valid      = (r_state == S_DONE);
  assign x          = r_x;
  assign y          = r_y;
  assign stage      = r_stage;
  assign pt_cnt     = r_pt_cnt;
  assign cfg_err    = r_cfg_err;

endmodule

// File: doc/scan_sequencer_p.md
SCAN_SEQUENCER_P -- requirements
Module: scan_sequencer_p

Interface
REQ-001 SHALL have parameter CW, default 4: coordinate width in bits.
REQ-002 SHALL have parameter STAGES, default 4: PROCESS cycles per point; legal range 1..256.
REQ-003 SHALL have parameter ORIGIN, default 1: first coordinate value on both axes.
REQ-004 SHALL have parameter SW, default max(1, clog2(STAGES)): stage output width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port en, input, 1: start request; sampled only in IDLE.
REQ-008 SHALL have port cfg_xmax, input, CW: last x value; latched at start.
REQ-009 SHALL have port cfg_ymax, input, CW: last y value; latched at start.
REQ-010 SHALL have port cfg_order, input, 1: scan order, latched at start; 0 = y inner loop, 1 = x inner loop.
REQ-011 SHALL have port ana_ready, input, 1: downstream accepts the ANALYZE beat.
REQ-012 SHALL have port abort, input, 1: cancels the scan in progress.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have ports x and y, each output, CW: current point coordinates.
REQ-015 SHALL have port stage, output, SW: current PROCESS cycle index.
REQ-016 SHALL have port analyze_en, output, 1: high in ANALYZE.
REQ-017 SHALL have port valid, output, 1: one-cycle pulse in DONE.
REQ-018 SHALL have port cfg_err, output, 1: one-cycle pulse on a rejected start.
REQ-019 SHALL have port pt_cnt, output, 2*CW: number of points completed in the current or most recent scan.

Function
REQ-020 SHALL implement the states IDLE, RECV, PROCESS, ANALYZE and DONE.
REQ-021 In IDLE with en=1 and legal config, SHALL latch cfg_xmax, cfg_ymax and cfg_order, clear pt_cnt, and go to RECV.
REQ-022 Config is legal only if cfg_xmax>=ORIGIN and cfg_ymax>=ORIGIN.
REQ-023 On a start with illegal config, SHALL stay in IDLE and pulse cfg_err for 1 cycle.
REQ-024 RECV SHALL last exactly 1 cycle, then go to PROCESS with stage=0.
REQ-025 PROCESS SHALL increment stage each cycle; when stage reaches STAGES-1, SHALL go to ANALYZE with stage returning to 0.
REQ-026 stage SHALL read 0 in every state other than PROCESS.
REQ-027 In ANALYZE with ana_ready=0, SHALL hold state, x, y and pt_cnt (stall).
REQ-028 In ANALYZE with ana_ready=1, SHALL increment pt_cnt (saturating at all-ones).
REQ-029 In ANALYZE with ana_ready=1 at the last point (x=xmax and y=ymax), SHALL go to DONE and set x and y to ORIGIN.
REQ-030 In ANALYZE with ana_ready=1 at any other point, SHALL advance the coordinates and go to PROCESS.
REQ-031 Advance rule for order 0: if y=ymax then x+1 and y=ORIGIN, else y+1.
REQ-032 Advance rule for order 1: if x=xmax then y+1 and x=ORIGIN, else x+1.
REQ-033 DONE SHALL last 1 cycle, then go to IDLE.
REQ-034 abort=1 in any state other than IDLE SHALL, next cycle: force IDLE, set x and y to ORIGIN, set stage to 0; valid is not asserted and pt_cnt is held.
REQ-035 abort SHALL have priority over ana_ready and stage completion.
REQ-036 abort in IDLE SHALL have no effect; en and abort together in IDLE SHALL start the scan.
REQ-037 en outside IDLE SHALL be ignored; config changes mid-scan SHALL have no effect.
REQ-038 Coordinate arithmetic SHALL be CW-bit; with xmax=ymax=2^CW-1, wrap is never reached because the last-point test precedes any increment.
REQ-039 Latency: with ana_ready held at 1, for N=(xmax-ORIGIN+1)*(ymax-ORIGIN+1) points, valid SHALL be high in cycle 2+N*(STAGES+1), counting the en-sampling cycle as 0.
REQ-040 Single-point grid (xmax=ymax=ORIGIN) SHALL produce exactly 1 PROCESS/ANALYZE pass followed by DONE.

Reset
REQ-041 While rst=1, regardless of clock, SHALL set: state=IDLE, x=y=ORIGIN, stage=0, pt_cnt=0, busy=0, analyze_en=0, valid=0, cfg_err=0.
REQ-042 Latched config SHALL reset to xmax=ymax=ORIGIN, order=0.
REQ-043 Reset mid-scan SHALL abandon the scan with no valid pulse.

Verification
REQ-044 Defaults, xmax=ymax=8, order 0, ana_ready=1, en pulse -> 64 ANALYZE beats visiting (1,1),(1,2)..(1,8),(2,1)..(8,8); valid in cycle 322; pt_cnt=64.
REQ-045 xmax=3, ymax=2, order 1, STAGES=2 -> visit order (1,1),(2,1),(3,1),(1,2),(2,2),(3,2); valid in cycle 20.
REQ-046 ana_ready low for 5 cycles at point (2,3) -> analyze_en held 5 extra cycles, x and y stable, pt_cnt unchanged; valid delayed by exactly 5 cycles.
REQ-047 abort asserted at stage=2 of the 10th point -> IDLE next cycle, busy=0, x=y=1, no valid, pt_cnt=9.
REQ-048 cfg_xmax=0 with en=1 -> cfg_err pulse, busy stays 0; async rst mid-PROCESS -> all outputs at reset values before the next clock edge.
